countdown_timer: RTL and testbench

- Down-counting MM:SS timer; the counterpart of the up-counting stopwatch, for the same 50 MHz board I/O (KEY, SW, HEX, LEDR).
- Operator loads a minute preset from switches, then starts and pauses with a key.
- Counts down once per second to 00:00, then raises an alarm LED.
- Drives four active-low seven-segment digits: HEX3:HEX2 show minutes, HEX1:HEX0 show seconds.

---
 rtl/countdown_timer.sv | 192 +++++++++++++++++++
 tb/tb_countdown_timer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// MM:SS down-counting timer with key-driven load/start/pause and a registered 7-segment display.
// Optional DONE-state display blink is enabled by defining COUNTDOWN_BLINK_EN.
module countdown_timer #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [9:0] LEDR
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    logic rst;
    assign rst = KEY[1];

    logic unused_inputs;
    assign unused_inputs = ^{KEY[3], SW[9:8]};

    // Bit 0 tracks the start/pause key, bit 1 the load key.
    logic [1:0] sync1_q, sync2_q, prev_q, ev_q, ev_d;
    state_t state_q, state_d;
    logic [3:0] m1_q, m0_q, s1_q, s0_q, m1_d, m0_d, s1_d, s0_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0] hex0_q, hex1_q, hex2_q, hex3_q, hex0_d, hex1_d, hex2_d, hex3_d;
    logic [9:0] led_q, led_d;
    logic start_ev, load_ev, tick, nonzero, blank;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        ev_d     = sync2_q & ~prev_q;
        start_ev = ev_q[0];
        load_ev  = ev_q[1];
        nonzero  = ({m1_q, m0_q, s1_q, s0_q} != '0);
        tick     = (state_q == RUN) && (presc_q == PRESC_MAX);
        state_d  = state_q;
        m1_d     = m1_q;
        m0_d     = m0_q;
        s1_d     = s1_q;
        s0_d     = s0_q;
        presc_d  = presc_q;

        if (load_ev && state_q != RUN) begin
            m1_d    = clamp_bcd(SW[7:4]);
            m0_d    = clamp_bcd(SW[3:0]);
            s1_d    = '0;
            s0_d    = '0;
            presc_d = '0;
            state_d = IDLE;
        end else if (start_ev) begin
            unique case (state_q)
                IDLE:    if (nonzero) state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                DONE:    state_d = DONE;
            endcase
        end else if (state_q == RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                if ({m1_q, m0_q, s1_q} == '0 && s0_q == 4'd1) state_d = DONE;
                // BCD borrow chain, least significant digit first
                if (s0_q != '0) begin
                    s0_d = s0_q - 4'd1;
                end else begin
                    s0_d = 4'd9;
                    if (s1_q != '0) begin
                        s1_d = s1_q - 4'd1;
                    end else begin
                        s1_d = 4'd5;
                        if (m0_q != '0) begin
                            m0_d = m0_q - 4'd1;
                        end else begin
                            m0_d = 4'd9;
                            m1_d = m1_q - 4'd1;
                        end
                    end
                end
            end
        end
    end

`ifdef COUNTDOWN_BLINK_EN
    localparam logic [PW-1:0] BLINK_MAX = PW'(TICK_DIV / 2 - 1);
    logic [PW-1:0] blink_cnt_q, blink_cnt_d;
    logic blink_on_q, blink_on_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (state_d == DONE && state_q != DONE) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (state_q == DONE) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign blank = (state_q == DONE) && !blink_on_q;
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        hex3_d = blank ? 7'h7F : seg7(m1_q);
        hex2_d = blank ? 7'h7F : seg7(m0_q);
        hex1_d = blank ? 7'h7F : seg7(s1_q);
        hex0_d = blank ? 7'h7F : seg7(s0_q);
        led_d  = {8'b0, state_q == RUN, state_q == DONE};
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            ev_q    <= '0;
            state_q <= IDLE;
            m1_q    <= '0;
            m0_q    <= '0;
            s1_q    <= '0;
            s0_q    <= '0;
            presc_q <= '0;
            hex0_q  <= 7'b1000000;
            hex1_q  <= 7'b1000000;
            hex2_q  <= 7'b1000000;
            hex3_q  <= 7'b1000000;
            led_q   <= '0;
        end else begin
            sync1_q <= {KEY[2], KEY[0]};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            ev_q    <= ev_d;
            state_q <= state_d;
            m1_q    <= m1_d;
            m0_q    <= m0_d;
            s1_q    <= s1_d;
            s0_q    <= s0_d;
            presc_q <= presc_d;
            hex0_q  <= hex0_d;
            hex1_q  <= hex1_d;
            hex2_q  <= hex2_d;
            hex3_q  <= hex3_d;
            led_q   <= led_d;
        end
    end

    assign HEX0 = hex0_q;
    assign HEX1 = hex1_q;
    assign HEX2 = hex2_q;
    assign HEX3 = hex3_q;
    assign LEDR = led_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4; DONE-display checks follow COUNTDOWN_BLINK_EN.
module tb_countdown_timer;
    logic       clk;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;
    logic [9:0] LEDR;
    int total;
    int bad;

    countdown_timer #(.TICK_DIV(4)) dut (
        .CLOCK_50(clk),
        .KEY(KEY),
        .SW(SW),
        .HEX0(HEX0),
        .HEX1(HEX1),
        .HEX2(HEX2),
        .HEX3(HEX3),
        .LEDR(LEDR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'h40;  1: seg = 7'h79;  2: seg = 7'h24;  3: seg = 7'h30;
            4: seg = 7'h19;  5: seg = 7'h12;  6: seg = 7'h02;  7: seg = 7'h78;
            8: seg = 7'h00;  9: seg = 7'h10;  default: seg = 7'h7F;
        endcase
    endfunction

    function automatic logic [27:0] disp(input int m1, input int m0, input int s1, input int s0);
        return {seg(m1), seg(m0), seg(s1), seg(s0)};
    endfunction

    function automatic logic [27:0] hexv();
        return {HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic do_reset();
        KEY[1] = 1'b1;
        repeat (2) @(negedge clk);
        KEY[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input int idx);
        KEY[idx] = 1'b1;
        repeat (2) @(negedge clk);
        KEY[idx] = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_disp(input logic [27:0] t, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (hexv() === t) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_run(input logic want, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (LEDR[1] === want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        KEY = 4'b0010;
        SW  = '0;
        repeat (2) @(negedge clk);
        total++;
        if (hexv() !== disp(0, 0, 0, 0)) begin
            bad++; $display("FAIL reset_hex got=%h want=%h", hexv(), disp(0, 0, 0, 0));
        end
        total++;
        if (LEDR !== 10'd0) begin bad++; $display("FAIL reset_led got=%b want=0", LEDR); end
        KEY[1] = 1'b0;
        SW = 10'h002;
        press(2);
        total++;
        if (hexv() !== disp(0, 2, 0, 0)) begin
            bad++; $display("FAIL load_02 got=%h want=%h", hexv(), disp(0, 2, 0, 0));
        end
        total++;
        if (LEDR !== 10'd0) begin bad++; $display("FAIL load_led got=%b want=0", LEDR); end
    endtask

    task automatic test_full_minute();
        bit ok;
        SW = 10'h001;
        press(2);
        KEY[0] = 1'b1;      // held across many cycles: must yield one start only
        wait_run(1'b1, 20, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL start_run got=%b want=1", LEDR[1]); end
        repeat (3) @(negedge clk);
        total++;
        if (hexv() !== disp(0, 1, 0, 0)) begin
            bad++; $display("FAIL pre_tick got=%h want=%h", hexv(), disp(0, 1, 0, 0));
        end
        @(negedge clk);
        total++;
        if (hexv() !== disp(0, 0, 5, 9)) begin
            bad++; $display("FAIL first_tick got=%h want=%h", hexv(), disp(0, 0, 5, 9));
        end
        KEY[0] = 1'b0;
        repeat (235) @(negedge clk);
        total++;
        if (hexv() !== disp(0, 0, 0, 1) || LEDR !== 10'b10) begin
            bad++; $display("FAIL at_0001 got=%h/%b want=%h/10", hexv(), LEDR, disp(0, 0, 0, 1));
        end
        @(negedge clk);
        total++;
        if (hexv() !== disp(0, 0, 0, 0) || LEDR !== 10'b01) begin
            bad++; $display("FAIL done got=%h/%b want=%h/01", hexv(), LEDR, disp(0, 0, 0, 0));
        end
    endtask

    // Entered on the first cycle the DONE outputs are visible.
    task automatic test_done();
        logic [27:0] want;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
`ifdef COUNTDOWN_BLINK_EN
            want = (((k / 2) % 2) == 0) ? disp(0, 0, 0, 0) : {4{7'h7F}};
`else
            want = disp(0, 0, 0, 0);
`endif
            total++;
            if (hexv() !== want || LEDR !== 10'b01) begin
                bad++; $display("FAIL done_disp k=%0d got=%h/%b want=%h/01", k, hexv(), LEDR, want);
            end
        end
        press(0);
        repeat (4) @(negedge clk);
        total++;
        if (LEDR !== 10'b01) begin bad++; $display("FAIL done_start got=%b want=01", LEDR); end
        SW = 10'h002;
        press(2);
        repeat (4) @(negedge clk);
        total++;
        if (hexv() !== disp(0, 2, 0, 0) || LEDR !== 10'd0) begin
            bad++; $display("FAIL done_load got=%h/%b want=%h/0", hexv(), LEDR, disp(0, 2, 0, 0));
        end
    endtask

    task automatic test_pause();
        bit ok;
        SW = 10'h001;
        press(2);
        KEY[0] = 1'b1;
        wait_run(1'b1, 20, ok);
        KEY[0] = 1'b0;
        wait_disp(disp(0, 0, 4, 6), 200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL reach_46 got=%h want=%h", hexv(), disp(0, 0, 4, 6)); end
        KEY[0] = 1'b1;
        wait_run(1'b0, 20, ok);
        KEY[0] = 1'b0;
        total++;
        if (!ok || hexv() !== disp(0, 0, 4, 5)) begin
            bad++; $display("FAIL paused_45 got=%h/%b want=%h", hexv(), LEDR, disp(0, 0, 4, 5));
        end
        repeat (100) @(negedge clk);
        total++;
        if (hexv() !== disp(0, 0, 4, 5) || LEDR !== 10'd0) begin
            bad++; $display("FAIL pause_hold got=%h/%b want=%h/0", hexv(), LEDR, disp(0, 0, 4, 5));
        end
        KEY[0] = 1'b1;
        wait_run(1'b1, 20, ok);
        KEY[0] = 1'b0;
        total++;
        if (!ok || hexv() !== disp(0, 0, 4, 5)) begin
            bad++; $display("FAIL resume got=%h/%b want=%h", hexv(), LEDR, disp(0, 0, 4, 5));
        end
        wait_disp(disp(0, 0, 4, 4), 4, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL partial_sec got=%h want=%h", hexv(), disp(0, 0, 4, 4)); end
    endtask

    task automatic test_clamp();
        bit ok;
        logic [27:0] exp_tab [4];
        exp_tab[0] = disp(9, 8, 5, 9);
        exp_tab[1] = disp(9, 8, 5, 8);
        exp_tab[2] = disp(9, 8, 5, 7);
        exp_tab[3] = disp(9, 8, 5, 6);
        do_reset();
        SW = 10'h0CF;
        press(2);
        total++;
        if (hexv() !== disp(9, 9, 0, 0)) begin
            bad++; $display("FAIL clamp got=%h want=%h", hexv(), disp(9, 9, 0, 0));
        end
        KEY[0] = 1'b1;
        wait_run(1'b1, 20, ok);
        KEY[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(negedge clk);
            total++;
            if (hexv() !== exp_tab[i]) begin
                bad++; $display("FAIL tick%0d got=%h want=%h", i, hexv(), exp_tab[i]);
            end
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        do_reset();
        press(0);
        repeat (4) @(negedge clk);
        total++;
        if (LEDR !== 10'd0 || hexv() !== disp(0, 0, 0, 0)) begin
            bad++; $display("FAIL start_at_zero got=%h/%b want=%h/0", hexv(), LEDR, disp(0, 0, 0, 0));
        end
        SW = 10'h003;
        press(2);
        press(0);
        press(0);
        total++;
        if (LEDR !== 10'd0) begin bad++; $display("FAIL to_pause got=%b want=0", LEDR); end
        SW = 10'h012;
        KEY[0] = 1'b1;
        KEY[2] = 1'b1;
        repeat (2) @(negedge clk);
        KEY[0] = 1'b0;
        KEY[2] = 1'b0;
        repeat (30) @(negedge clk);
        total++;
        if (hexv() !== disp(1, 2, 0, 0) || LEDR !== 10'd0) begin
            bad++; $display("FAIL load_wins got=%h/%b want=%h/0", hexv(), LEDR, disp(1, 2, 0, 0));
        end
        wait_run(1'b1, 2, ok);
        total++;
        if (ok) begin bad++; $display("FAIL load_wins_run got=%b want=0", LEDR[1]); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        do_reset();
        SW = 10'h006;
        press(2);
        press(0);
        wait_disp(disp(0, 5, 1, 7), 400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL reach_0517 got=%h want=%h", hexv(), disp(0, 5, 1, 7)); end
        KEY[1] = 1'b1;
        @(negedge clk);
        total++;
        if (hexv() !== disp(0, 0, 0, 0) || LEDR !== 10'd0) begin
            bad++; $display("FAIL mid_reset got=%h/%b want=%h/0", hexv(), LEDR, disp(0, 0, 0, 0));
        end
        KEY[1] = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (hexv() !== disp(0, 0, 0, 0) || LEDR !== 10'd0) begin
            bad++; $display("FAIL after_reset got=%h/%b want=%h/0", hexv(), LEDR, disp(0, 0, 0, 0));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_full_minute();
        test_done();
        test_pause();
        test_clamp();
        test_simultaneous();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
